// File: rtl/add_pipe_pkg.sv
// Shared definitions for the pipelined adder: ALU opcode encodings and the legal-split check.
package add_pipe_pkg;

    // The future ALU decode maps its opcode onto the `sub` input through these.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic bit legal_split(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/add_chunk_pg.sv
// Combinational C-bit adder slice with ripple carry-out and group propagate/generate.
module add_chunk_pg #(
    parameter int unsigned C = 8
) (
    input  logic [C-1:0] a_i,
    input  logic [C-1:0] b_i,
    input  logic         c_i,
    output logic [C-1:0] s_o,
    output logic         c_o,
    output logic         pg_o,
    output logic         gg_o
);

    logic [C-1:0] p;
    logic [C-1:0] g;
    logic [C:0]   cy;
    logic         gg;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    always_comb begin
        cy    = '0;
        cy[0] = c_i;
        for (int i = 0; i < int'(C); i++) begin
            cy[i+1] = g[i] | (p[i] & cy[i]);
        end
    end

    // Group generate: carry out of the slice assuming a zero carry in.
    always_comb begin
        gg = 1'b0;
        for (int i = 0; i < int'(C); i++) begin
            gg = g[i] | (p[i] & gg);
        end
    end

    assign s_o  = p ^ cy[C-1:0];
    assign c_o  = cy[C];
    assign pg_o = &p;
    assign gg_o = gg;

endmodule

// File: rtl/add_pipe.sv
// Pipelined add/subtract: one C-bit chunk per stage, carry registered between stages,
// valid/ready handshake with a single global advance enable.
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned C = WIDTH / STAGES;

    if (!legal_split(WIDTH, STAGES)) begin : g_bad_split
        $error("add_pipe: WIDTH must be a non-zero multiple of STAGES");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;

    assign b_eff    = (sub == OP_SUB) ? ~b : b;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int unsigned ResW = (k + 1) * C;  // finished result bits after this stage
        localparam int unsigned HiW  = WIDTH - ResW; // operand bits still to be added

        logic [C-1:0]    a_ck;
        logic [C-1:0]    b_ck;
        logic [C-1:0]    sum_ck;
        logic            c_ck;
        logic            v_in;
        logic            pg;
        logic            gg;
        logic            co;
        logic            load;
        logic [ResW-1:0] res_new;
        logic            valid_d, valid_q;
        logic            carry_d, carry_q;
        logic [ResW-1:0] res_d, res_q;

        if (k == 0) begin : g_head
            assign a_ck    = a[C-1:0];
            assign b_ck    = b_eff[C-1:0];
            assign c_ck    = cin;
            assign v_in    = in_valid;
            assign res_new = sum_ck;
        end else begin : g_body
            assign a_ck    = g_st[k-1].g_hi.a_hi_q[C-1:0];
            assign b_ck    = g_st[k-1].g_hi.b_hi_q[C-1:0];
            assign c_ck    = g_st[k-1].carry_q;
            assign v_in    = g_st[k-1].valid_q;
            assign res_new = {sum_ck, g_st[k-1].res_q};
        end

        add_chunk_pg #(
            .C (C)
        ) u_chunk (
            .a_i  (a_ck),
            .b_i  (b_ck),
            .c_i  (c_ck),
            .s_o  (sum_ck),
            .c_o  (co),
            .pg_o (pg),
            .gg_o (gg)
        );

        // Lookahead carry must agree with the slice's own ripple carry.
        carry_lookahead_a: assert property (@(posedge clk) disable iff (!rst_n)
            co == (gg | (pg & c_ck)));

        // Data only loads for a real beat so an invalid output keeps its last value.
        assign load = en && v_in;

        always_comb begin
            valid_d = en ? v_in : valid_q;
            carry_d = carry_q;
            res_d   = res_q;
            if (load) begin
                carry_d = gg | (pg & c_ck);
                res_d   = res_new;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                res_q   <= '0;
            end else begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                res_q   <= res_d;
            end
        end

        if (HiW > 0) begin : g_hi
            logic [HiW-1:0] a_hi_src, b_hi_src;
            logic [HiW-1:0] a_hi_d, a_hi_q;
            logic [HiW-1:0] b_hi_d, b_hi_q;

            if (k == 0) begin : g_src_in
                assign a_hi_src = a[WIDTH-1:C];
                assign b_hi_src = b_eff[WIDTH-1:C];
            end else begin : g_src_prev
                assign a_hi_src = g_st[k-1].g_hi.a_hi_q[HiW+C-1:C];
                assign b_hi_src = g_st[k-1].g_hi.b_hi_q[HiW+C-1:C];
            end

            always_comb begin
                a_hi_d = a_hi_q;
                b_hi_d = b_hi_q;
                if (load) begin
                    a_hi_d = a_hi_src;
                    b_hi_d = b_hi_src;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_hi_q <= '0;
                    b_hi_q <= '0;
                end else begin
                    a_hi_q <= a_hi_d;
                    b_hi_q <= b_hi_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_tail
            logic ovf_d, ovf_q;
            logic zero_d, zero_q;

            // The top chunk carries the operand sign bits, so flags need no extra cycle.
            always_comb begin
                ovf_d  = ovf_q;
                zero_d = zero_q;
                if (load) begin
                    ovf_d  = (a_ck[C-1] == b_ck[C-1]) && (sum_ck[C-1] != a_ck[C-1]);
                    zero_d = ~|res_new;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else begin
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].valid_q;
    assign s         = g_st[STAGES-1].res_q;
    assign cout      = g_st[STAGES-1].carry_q;
    assign ovf       = g_st[STAGES-1].g_tail.ovf_q;
    assign zero      = g_st[STAGES-1].g_tail.zero_q;

endmodule
